bcd_counter_ndigit: RTL and testbench

- Parametrised multi-decade synchronous BCD counter; the successor to the single-decade T-flip-flop BCD counter.
- Adds runtime direction (up/down), parallel load, synchronous clear, selectable wrap or saturate at the limits, a cascade terminal-count output and a sticky overflow flag.
- Used as the display/event counter in the timing and stopwatch datapaths; instances cascade through Tc into En.

---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_decade.sv | 31 +++
 rtl/bcd_counter_ndigit.sv | 76 +++++++
 tb/tb_bcd_counter_ndigit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared decade constants and the nibble clamp used on parallel load.
package bcd_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] DIGIT_MIN = 4'd0;
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: one BCD digit with clear > load > step priority and limit flags.
module bcd_decade
    import bcd_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_step,
    input  logic         i_up,
    input  logic         i_clr,
    input  logic         i_ld,
    input  logic [3:0]   i_din,
    output logic [3:0]   o_q,
    output logic         o_at_max,
    output logic         o_at_min
);
    logic [3:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= DIGIT_MIN;
        else if (i_clr)
            r_q <= DIGIT_MIN;
        else if (i_ld)
            r_q <= clamp_digit(i_din);
        else if (i_step)
            r_q <= i_up ? (o_at_max ? DIGIT_MIN : r_q + 4'd1)
                        : (o_at_min ? DIGIT_MAX : r_q - 4'd1);
    end
    assign o_q      = r_q;
    assign o_at_max = (r_q == DIGIT_MAX);
    assign o_at_min = (r_q == DIGIT_MIN);
endmodule

// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: cascadable multi-decade up/down BCD counter with load,
// clear, wrap/saturate, terminal count and sticky overflow.
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_up,
    input  logic                    i_clr,
    input  logic                    i_load,
    input  logic [DIGIT_W*DIGITS-1:0] i_din,
    output logic [DIGIT_W*DIGITS-1:0] o_q,
    output logic                    o_tc,
    output logic                    o_ovf,
    output logic                    o_load_err
);
    logic [DIGITS:0]   w_maxc;
    logic [DIGITS:0]   w_minc;
    logic [DIGITS-1:0] w_max;
    logic [DIGITS-1:0] w_min;
    logic [DIGITS-1:0] w_step;
    logic [DIGITS-1:0] w_bad;
    logic              w_limit;
    logic              w_go;
    logic              r_ovf;
    logic              r_load_err;

    // w_maxc[k]/w_minc[k]: every decade below k sits at 9 / at 0
    assign w_maxc[0] = 1'b1;
    assign w_minc[0] = 1'b1;
    assign w_limit   = i_up ? w_maxc[DIGITS] : w_minc[DIGITS];
    assign w_go      = i_en & (WRAP | ~w_limit);

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_dec
            assign w_maxc[k+1] = w_maxc[k] & w_max[k];
            assign w_minc[k+1] = w_minc[k] & w_min[k];
            assign w_step[k]   = w_go & (i_up ? w_maxc[k] : w_minc[k]);
            assign w_bad[k]    = i_din[DIGIT_W*k +: DIGIT_W] > DIGIT_MAX;
            bcd_decade u_dec (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_step   (w_step[k]),
                .i_up     (i_up),
                .i_clr    (i_clr),
                .i_ld     (i_load),
                .i_din    (i_din[DIGIT_W*k +: DIGIT_W]),
                .o_q      (o_q[DIGIT_W*k +: DIGIT_W]),
                .o_at_max (w_max[k]),
                .o_at_min (w_min[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= ~i_clr & i_load & (|w_bad);
            if (i_clr | i_load)
                r_ovf <= 1'b0;
            else if (i_en & w_limit)
                r_ovf <= 1'b1;
        end
    end

    assign o_tc       = i_en & w_limit;
    assign o_ovf      = r_ovf;
    assign o_load_err = r_load_err;
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: directed vectors for wrap, saturate and cascaded instances.
module tb_bcd_counter_ndigit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_en, a_up, a_clr, a_ld;
    logic [15:0] a_din, a_q;
    logic        a_tc, a_ovf, a_lerr;
    logic        s_en, s_up, s_clr, s_ld;
    logic [15:0] s_din, s_q;
    logic        s_tc, s_ovf, s_lerr;
    logic        c_en, c_up, c_zero;
    logic [7:0]  c_din, lo_q, hi_q;
    logic        lo_tc, lo_ovf, lo_lerr, hi_tc, hi_ovf, hi_lerr;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    bcd_counter_ndigit #(.DIGITS(4), .WRAP(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_up(a_up), .i_clr(a_clr),
        .i_load(a_ld), .i_din(a_din), .o_q(a_q), .o_tc(a_tc), .o_ovf(a_ovf),
        .o_load_err(a_lerr));
    bcd_counter_ndigit #(.DIGITS(4), .WRAP(1'b0)) u_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(s_en), .i_up(s_up), .i_clr(s_clr),
        .i_load(s_ld), .i_din(s_din), .o_q(s_q), .o_tc(s_tc), .o_ovf(s_ovf),
        .o_load_err(s_lerr));
    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1'b1)) u_lo (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(c_en), .i_up(c_up), .i_clr(c_zero),
        .i_load(c_zero), .i_din(c_din), .o_q(lo_q), .o_tc(lo_tc), .o_ovf(lo_ovf),
        .o_load_err(lo_lerr));
    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1'b1)) u_hi (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(lo_tc), .i_up(c_up), .i_clr(c_zero),
        .i_load(c_zero), .i_din(c_din), .o_q(hi_q), .o_tc(hi_tc), .o_ovf(hi_ovf),
        .o_load_err(hi_lerr));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_en, a_up, a_clr, a_ld, a_din} = '0;
        {s_en, s_up, s_clr, s_ld, s_din} = '0;
        {c_en, c_up, c_zero, c_din} = '0;
        tick(2);
        chk("rst_q", a_q, 16'h0000);
        chk("rst_ovf", {15'd0, a_ovf}, 16'd0);
        chk("rst_lerr", {15'd0, a_lerr}, 16'd0);
        chk("rst_tc_en0", {15'd0, a_tc}, 16'd0);
        a_en = 1'b1;
        #1 chk("rst_tc_down", {15'd0, a_tc}, 16'd1);
        a_up = 1'b1;
        #1 chk("rst_tc_up", {15'd0, a_tc}, 16'd0);

        rst_n = 1'b1;
        tick(37);
        chk("pre_reset_cnt", a_q, 16'h0037);
        rst_n = 1'b0;
        #1 chk("async_reset", a_q, 16'h0000);
        rst_n = 1'b1;
        tick(1234);
        chk("count_1234", a_q, 16'h1234);
        chk("count_ovf", {15'd0, a_ovf}, 16'd0);
        a_en = 1'b0;

        a_ld = 1'b1; a_din = 16'h9998;
        tick();
        a_ld = 1'b0;
        chk("load_9998", a_q, 16'h9998);
        a_en = 1'b1; a_up = 1'b1;
        tick();
        chk("up_9999", a_q, 16'h9999);
        chk("tc_9999", {15'd0, a_tc}, 16'd1);
        chk("ovf_9999", {15'd0, a_ovf}, 16'd0);
        tick();
        chk("wrap_0000", a_q, 16'h0000);
        chk("wrap_ovf", {15'd0, a_ovf}, 16'd1);
        chk("wrap_tc", {15'd0, a_tc}, 16'd0);
        tick();
        chk("wrap_0001", a_q, 16'h0001);
        chk("ovf_sticky", {15'd0, a_ovf}, 16'd1);
        a_en = 1'b0;

        a_ld = 1'b1; a_din = 16'hA3F7;
        tick();
        a_ld = 1'b0;
        chk("clamp_q", a_q, 16'h9397);
        chk("clamp_lerr", {15'd0, a_lerr}, 16'd1);
        chk("clamp_ovf", {15'd0, a_ovf}, 16'd0);
        a_en = 1'b1;
        tick();
        chk("after_clamp", a_q, 16'h9398);
        chk("lerr_pulse", {15'd0, a_lerr}, 16'd0);
        a_en = 1'b0;

        a_ld = 1'b1; a_din = 16'h9999;
        tick();
        a_ld = 1'b0; a_en = 1'b1;
        tick();
        chk("ovf_before_clr", {15'd0, a_ovf}, 16'd1);
        a_clr = 1'b1; a_ld = 1'b1; a_din = 16'h5555;
        tick();
        chk("prio_clr_q", a_q, 16'h0000);
        chk("prio_clr_ovf", {15'd0, a_ovf}, 16'd0);
        a_din = 16'hFFFF;
        tick();
        chk("clr_masks_lerr", {15'd0, a_lerr}, 16'd0);
        a_clr = 1'b0; a_din = 16'h0042;
        tick();
        chk("prio_load", a_q, 16'h0042);
        a_ld = 1'b0;
        tick();
        chk("up_0043", a_q, 16'h0043);
        a_up = 1'b0;
        tick();
        chk("dir_change", a_q, 16'h0042);
        a_en = 1'b0; a_ld = 1'b1; a_din = 16'h1000;
        tick();
        a_ld = 1'b0; a_en = 1'b1;
        tick();
        chk("borrow", a_q, 16'h0999);
        a_en = 1'b0;

        s_ld = 1'b1; s_din = 16'h0002;
        tick();
        s_ld = 1'b0; s_en = 1'b1; s_up = 1'b0;
        tick();
        chk("sat_0001", s_q, 16'h0001);
        chk("sat_tc_0001", {15'd0, s_tc}, 16'd0);
        tick();
        chk("sat_0000", s_q, 16'h0000);
        chk("sat_ovf_e2", {15'd0, s_ovf}, 16'd0);
        chk("sat_tc", {15'd0, s_tc}, 16'd1);
        tick();
        chk("sat_hold", s_q, 16'h0000);
        chk("sat_ovf_e3", {15'd0, s_ovf}, 16'd1);
        tick();
        chk("sat_hold2", s_q, 16'h0000);
        chk("sat_tc2", {15'd0, s_tc}, 16'd1);
        s_en = 1'b0;
        #1 chk("sat_tc_en0", {15'd0, s_tc}, 16'd0);
        s_ld = 1'b1; s_din = 16'h9999;
        tick();
        s_ld = 1'b0; s_en = 1'b1; s_up = 1'b1;
        tick();
        chk("sat_up_hold", s_q, 16'h9999);
        chk("sat_up_ovf", {15'd0, s_ovf}, 16'd1);
        s_en = 1'b0;

        c_en = 1'b1; c_up = 1'b1;
        tick(150);
        chk("casc_up", {hi_q, lo_q}, 16'h0150);
        chk("casc_lo_ovf", {15'd0, lo_ovf}, 16'd1);
        chk("casc_hi_ovf", {15'd0, hi_ovf}, 16'd0);
        c_up = 1'b0;
        tick(151);
        chk("casc_down", {hi_q, lo_q}, 16'h9999);
        chk("casc_lo_ovf2", {15'd0, lo_ovf}, 16'd1);
        chk("casc_hi_ovf2", {15'd0, hi_ovf}, 16'd1);
        c_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
